// File: rtl/interrupt_aggregator.sv
// Multi-channel interrupt aggregator: latches per-channel event strobes into pending bits
// and drives one active-low host interrupt line in pulse mode or level mode.
module interrupt_aggregator #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int MIN_CYCLES = 128,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [NUM_CH-1:0] ack_i,
  input  logic              level_mode_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic              busy_o,
  output logic              intN_o
);

  if (NUM_CH < 1 || NUM_CH > 32 || MIN_CYCLES < 1 || GAP_CYCLES < 1 ||
      (64'd1 << CNT_W) <= 64'(MIN_CYCLES) || (64'd1 << CNT_W) <= 64'(GAP_CYCLES)) begin : gParamCheck
    $error("interrupt_aggregator: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StHold,
    StGap
  } state_t;

  localparam logic [CNT_W-1:0] MinLast = CNT_W'(MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_CYCLES - 1);

  state_t            state_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;
  logic [CNT_W-1:0]  count_q;
  logic              startHit_q;
  logic              retrig_q;
  logic              mode_q;
  logic              intN_q;
  logic              req;

  assign pending_d = (pending_q & ~ack_i) | start_i;
  assign req       = |(pending_q & ~mask_i);

  // startHit_q marks an unmasked strobe from the previous cycle; it both opens a pulse
  // from IDLE and arms one retrigger while a pulse or gap is running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      count_q    <= '0;
      startHit_q <= 1'b0;
      retrig_q   <= 1'b0;
      mode_q     <= 1'b0;
      intN_q     <= 1'b1;
    end else begin
      pending_q  <= pending_d;
      startHit_q <= |(start_i & ~mask_i);
      case (state_q)
        StIdle: begin
          if (level_mode_i ? req : (startHit_q && req)) begin
            state_q  <= StAssert;
            mode_q   <= level_mode_i;
            count_q  <= '0;
            intN_q   <= 1'b0;
            retrig_q <= 1'b0;
          end
        end
        StAssert: begin
          if (startHit_q) retrig_q <= 1'b1;
          if (count_q == MinLast) begin
            if (mode_q && req) begin
              state_q <= StHold;
            end else begin
              state_q <= StGap;
              intN_q  <= 1'b1;
              count_q <= '0;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        StHold: begin
          if (!req) begin
            state_q <= StGap;
            intN_q  <= 1'b1;
            count_q <= '0;
          end
        end
        StGap: begin
          if (count_q == GapLast) begin
            count_q  <= '0;
            retrig_q <= 1'b0;
            // A strobe landing on the final gap cycle counts as a retrigger so it is not lost.
            if (mode_q ? req : ((retrig_q || startHit_q) && req)) begin
              state_q <= StAssert;
              intN_q  <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            count_q <= count_q + 1'b1;
            if (startHit_q) retrig_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          intN_q  <= 1'b1;
        end
      endcase
    end
  end

  assign pending_o = pending_q;
  assign busy_o    = (state_q != StIdle);
  assign intN_o    = intN_q;

endmodule

// File: tb/tb_interrupt_aggregator.sv
// Directed bench for interrupt_aggregator: a vector table for pending/mask/ack latching
// plus hand-timed sequences for pulse, retrigger, level, multi-channel and reset cases.
module tb_interrupt_aggregator;

  logic       clk;
  logic       rst_n;
  logic [3:0] start;
  logic [3:0] mask;
  logic [3:0] ack;
  logic       levelMode;
  logic [3:0] pending;
  logic       busy;
  logic       intN;

  int errors;
  int checks;
  int cyc;

  typedef struct {
    logic [3:0] start;
    logic [3:0] mask;
    logic [3:0] ack;
    logic [3:0] expPending;
    logic       expIntN;
    logic       expBusy;
  } vec_t;

  vec_t vecs[8];

  interrupt_aggregator #(
    .NUM_CH(4), .CNT_W(8), .MIN_CYCLES(128), .GAP_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .mask_i(mask),
    .ack_i(ack),
    .level_mode_i(levelMode),
    .pending_o(pending),
    .busy_o(busy),
    .intN_o(intN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Advance one clock; strobes are single-cycle so they drop after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    start = '0;
    ack   = '0;
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start;
    mask  = v.mask;
    ack   = v.ack;
    step();
  endtask

  task automatic checkState(input string name, input logic [3:0] expPending,
                            input logic expIntN, input logic expBusy);
    checkOutput({name, ".pending"}, 32'(pending), 32'(expPending));
    checkOutput({name, ".intN"}, 32'(intN), 32'(expIntN));
    checkOutput({name, ".busy"}, 32'(busy), 32'(expBusy));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = '0;
    mask      = '0;
    ack       = '0;
    levelMode = 1'b0;

    vecs[0] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[1] = '{4'h5, 4'hF, 4'h0, 4'h5, 1'b1, 1'b0};
    vecs[2] = '{4'h2, 4'hF, 4'h4, 4'h3, 1'b1, 1'b0};
    vecs[3] = '{4'h1, 4'hF, 4'h1, 4'h3, 1'b1, 1'b0};
    vecs[4] = '{4'h0, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 1'b0};
    vecs[6] = '{4'h0, 4'h8, 4'h0, 4'h8, 1'b1, 1'b0};
    vecs[7] = '{4'h0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    checkState("reset", 4'h0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].expPending, vecs[i].expIntN, vecs[i].expBusy);
    end

    // Single pulse in pulse mode
    mask = '0; levelMode = 1'b0; stepTo(cyc + 2);
    cyc = 0; start = 4'b0001; step();
    checkState("pulse.c1", 4'h1, 1'b1, 1'b0);
    stepTo(2);   checkState("pulse.c2", 4'h1, 1'b0, 1'b1);
    stepTo(129); checkState("pulse.c129", 4'h1, 1'b0, 1'b1);
    stepTo(130); checkState("pulse.c130", 4'h1, 1'b1, 1'b1);
    stepTo(133); checkState("pulse.c133", 4'h1, 1'b1, 1'b1);
    stepTo(134); checkState("pulse.c134", 4'h1, 1'b1, 1'b0);
    stepTo(160); checkState("pulse.noRefire", 4'h1, 1'b1, 1'b0);
    ack = 4'hF; step();
    checkOutput("pulse.ackClear", 32'(pending), 32'h0);

    // Retrigger: one extra pulse for a strobe during the first pulse
    cyc = 0; start = 4'b0001; step();
    stepTo(50); start = 4'b0100; step();
    stepTo(129); checkState("retrig.c129", 4'h5, 1'b0, 1'b1);
    stepTo(130); checkState("retrig.c130", 4'h5, 1'b1, 1'b1);
    stepTo(133); checkState("retrig.c133", 4'h5, 1'b1, 1'b1);
    stepTo(134); checkState("retrig.c134", 4'h5, 1'b0, 1'b1);
    stepTo(261); checkState("retrig.c261", 4'h5, 1'b0, 1'b1);
    stepTo(262); checkState("retrig.c262", 4'h5, 1'b1, 1'b1);
    stepTo(266); checkState("retrig.c266", 4'h5, 1'b1, 1'b0);
    stepTo(400); checkState("retrig.noThird", 4'h5, 1'b1, 1'b0);
    ack = 4'hF; step();

    // Level mode: held low until acked
    levelMode = 1'b1;
    cyc = 0; start = 4'b0010; step();
    stepTo(2);   checkState("level.c2", 4'h2, 1'b0, 1'b1);
    stepTo(130); checkState("level.c130", 4'h2, 1'b0, 1'b1);
    stepTo(300); checkState("level.c300", 4'h2, 1'b0, 1'b1);
    ack = 4'b0010; step();
    checkState("level.c301", 4'h0, 1'b0, 1'b1);
    stepTo(302); checkState("level.c302", 4'h0, 1'b1, 1'b1);
    stepTo(305); checkState("level.c305", 4'h0, 1'b1, 1'b1);
    stepTo(306); checkState("level.c306", 4'h0, 1'b1, 1'b0);
    levelMode = 1'b0;
    stepTo(310);

    // Simultaneous channels: exactly one pulse, pending held until acked
    cyc = 0; start = 4'b1111; step();
    stepTo(2);   checkState("multi.c2", 4'hF, 1'b0, 1'b1);
    stepTo(129); checkState("multi.c129", 4'hF, 1'b0, 1'b1);
    stepTo(130); checkState("multi.c130", 4'hF, 1'b1, 1'b1);
    stepTo(134); checkState("multi.c134", 4'hF, 1'b1, 1'b0);
    stepTo(300); checkState("multi.c300", 4'hF, 1'b1, 1'b0);
    ack = 4'hF; step();
    checkOutput("multi.ackClear", 32'(pending), 32'h0);

    // Asynchronous reset in the middle of a pulse
    cyc = 0; start = 4'b0001; step();
    stepTo(60); checkState("rst.before", 4'h1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    checkState("rst.async", 4'h0, 1'b1, 1'b0);
    step(); step();
    rst_n = 1'b1;
    stepTo(70);  checkState("rst.after", 4'h0, 1'b1, 1'b0);
    stepTo(250); checkState("rst.noPulse", 4'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
